// File: rtl/flag_stripes_anim_pkg.sv
// -----------------------------------------------------------------------------
// flag_stripes_anim_pkg
// Shared definitions for the pride-flag generators:
//   - RGB222 colour width and named colour constants (RRGGBB)
//   - animation mode encodings
//   - default emblem geometry and colour (used only when FLAG_EMBLEM_EN is set)
//   - dim_rgb(): halves every 2-bit channel (used by the breathe animation)
// -----------------------------------------------------------------------------
package flag_stripes_anim_pkg;

  localparam int RGB_W = 6;

  localparam logic [RGB_W-1:0] BLACK  = 6'b000000;
  localparam logic [RGB_W-1:0] RED    = 6'b110000;
  localparam logic [RGB_W-1:0] ORANGE = 6'b111000;
  localparam logic [RGB_W-1:0] YELLOW = 6'b111100;
  localparam logic [RGB_W-1:0] GREEN  = 6'b001100;
  localparam logic [RGB_W-1:0] BLUE   = 6'b000011;
  localparam logic [RGB_W-1:0] PURPLE = 6'b100010;
  localparam logic [RGB_W-1:0] WHITE  = 6'b111111;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_SCROLL  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Emblem (pi glyph) geometry, in pixels
  localparam int EMB_X   = 250;
  localparam int EMB_Y   = 190;
  localparam int EMB_W   = 140;
  localparam int BAR_H   = 20;
  localparam int LEG_W   = 20;
  localparam int LEG_H   = 90;
  localparam int LEG_GAP = 40;
  localparam logic [RGB_W-1:0] EMB_COLOR = YELLOW;

  // Shift each 2-bit channel right by one: 11->01, 10->01, 01->00
  function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] c);
    return {1'b0, c[5], 1'b0, c[3], 1'b0, c[1]};
  endfunction

endpackage

// File: rtl/flag_stripes_anim_emblem.sv
// -----------------------------------------------------------------------------
// flag_emblem
// Purely combinational hit test for a pi-shaped emblem: one horizontal bar
// across the top and two vertical legs hanging below it, the legs centred
// under the bar with LEG_GAP pixels between them.
// Only compiled into the design when FLAG_EMBLEM_EN is defined.
//   i_pix_x  [9:0]  current column
//   i_pix_y  [9:0]  current line
//   o_hit           1 when (i_pix_x, i_pix_y) lies on the glyph
// -----------------------------------------------------------------------------
module flag_emblem
  import flag_stripes_anim_pkg::*;
#(
  parameter int P_EMB_X   = EMB_X,
  parameter int P_EMB_Y   = EMB_Y,
  parameter int P_EMB_W   = EMB_W,
  parameter int P_BAR_H   = BAR_H,
  parameter int P_LEG_W   = LEG_W,
  parameter int P_LEG_H   = LEG_H,
  parameter int P_LEG_GAP = LEG_GAP
) (
  input  logic [9:0] i_pix_x,
  input  logic [9:0] i_pix_y,
  output logic       o_hit
);

  // 11-bit bounds so right/bottom edges near 1023 cannot wrap
  localparam int LEG_X0 = P_EMB_X + (P_EMB_W - 2*P_LEG_W - P_LEG_GAP) / 2;
  localparam int LEG_X1 = LEG_X0 + P_LEG_W + P_LEG_GAP;

  localparam logic [10:0] BAR_X_LO  = 11'(P_EMB_X);
  localparam logic [10:0] BAR_X_HI  = 11'(P_EMB_X + P_EMB_W);
  localparam logic [10:0] BAR_Y_LO  = 11'(P_EMB_Y);
  localparam logic [10:0] BAR_Y_HI  = 11'(P_EMB_Y + P_BAR_H);
  localparam logic [10:0] LEG_Y_HI  = 11'(P_EMB_Y + P_BAR_H + P_LEG_H);
  localparam logic [10:0] LEGL_X_LO = 11'(LEG_X0);
  localparam logic [10:0] LEGL_X_HI = 11'(LEG_X0 + P_LEG_W);
  localparam logic [10:0] LEGR_X_LO = 11'(LEG_X1);
  localparam logic [10:0] LEGR_X_HI = 11'(LEG_X1 + P_LEG_W);

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_bar;
  logic        w_leg_rows;
  logic        w_leg_cols;

  assign w_x        = {1'b0, i_pix_x};
  assign w_y        = {1'b0, i_pix_y};
  assign w_bar      = (w_x >= BAR_X_LO) && (w_x < BAR_X_HI) &&
                      (w_y >= BAR_Y_LO) && (w_y < BAR_Y_HI);
  assign w_leg_rows = (w_y >= BAR_Y_HI) && (w_y < LEG_Y_HI);
  assign w_leg_cols = ((w_x >= LEGL_X_LO) && (w_x < LEGL_X_HI)) ||
                      ((w_x >= LEGR_X_LO) && (w_x < LEGR_X_HI));
  assign o_hit      = w_bar || (w_leg_rows && w_leg_cols);

endmodule

// File: rtl/flag_stripes_anim.sv
// -----------------------------------------------------------------------------
// flag_stripes_anim
// N-stripe horizontal flag generator with frame-synchronous animation.
// The stripe index is tracked incrementally once per line (no divider), the
// palette is a parameter, and the output is a registered RGB222 colour with
// one cycle of latency relative to the pixel coordinates.
// Optional feature: define FLAG_EMBLEM_EN to overlay a pi emblem that wins over
// the stripe colour and is not affected by scroll or breathe.
//   i_clk           pixel clock
//   i_rst_n         asynchronous active-low reset
//   i_pix_x  [9:0]  current column
//   i_pix_y  [9:0]  current line
//   i_video_active  high inside the visible area
//   i_mode   [1:0]  0 static, 1 scroll, 2 breathe, 3 reserved (static)
//   o_color  [5:0]  registered RRGGBB
// -----------------------------------------------------------------------------
module flag_stripes_anim
  import flag_stripes_anim_pkg::*;
#(
  parameter int                           NUM_STRIPES = 3,
  parameter int                           V_ACTIVE    = 480,
  parameter int                           H_ACTIVE    = 640,
  parameter logic [NUM_STRIPES*RGB_W-1:0] PALETTE     = {BLACK, RED, BLUE},
  parameter int                           SPEED       = 30
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [9:0]       i_pix_x,
  input  logic [9:0]       i_pix_y,
  input  logic             i_video_active,
  input  logic [1:0]       i_mode,
  output logic [RGB_W-1:0] o_color
);

  localparam int STRIPE_H = V_ACTIVE / NUM_STRIPES;
  localparam int SW       = $clog2(NUM_STRIPES);
  localparam int FW       = (SPEED > 1) ? $clog2(SPEED) : 1;

  localparam logic [9:0]    ROW_LAST    = 10'(STRIPE_H - 1);
  localparam logic [9:0]    Y_FRAME     = 10'(V_ACTIVE);
  localparam logic [9:0]    X_END       = 10'(H_ACTIVE);
  localparam logic [SW-1:0] STRIPE_LAST = SW'(NUM_STRIPES - 1);
  localparam logic [SW:0]   STRIPE_NUM  = (SW+1)'(NUM_STRIPES);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(SPEED - 1);

  logic [9:0]       r_row_cnt;
  logic [SW-1:0]    r_stripe;
  logic [FW-1:0]    r_frame_cnt;
  logic [SW-1:0]    r_phase;
  mode_e            r_mode_q;
  logic [RGB_W-1:0] r_color;

  logic             w_line_start;
  logic             w_frame_edge;
  logic             w_frame_wrap;
  logic             w_phase_run;
  logic [9:0]       w_row_nxt;
  logic [SW-1:0]    w_stripe_nxt;
  logic [SW:0]      w_sum;
  logic [SW-1:0]    w_pal_idx;
  logic [RGB_W-1:0] w_pal_rgb;
  logic [RGB_W-1:0] w_stripe_rgb;
  logic             w_visible;
  logic [RGB_W-1:0] w_color_nxt;

  assign w_line_start = (i_pix_x == 10'd0);
  assign w_frame_edge = w_line_start && (i_pix_y == Y_FRAME);
  assign w_frame_wrap = (r_frame_cnt == FRAME_LAST);
  assign w_phase_run  = (r_mode_q == MODE_SCROLL) || (r_mode_q == MODE_BREATHE);
  assign w_visible    = i_video_active && (i_pix_x < X_END);

  // Row/stripe tracking; the pix_x==0 cycle already colours with the new stripe
  always_comb begin
    w_row_nxt    = r_row_cnt;
    w_stripe_nxt = r_stripe;
    if (w_line_start) begin
      if (i_pix_y == 10'd0) begin
        w_row_nxt    = '0;
        w_stripe_nxt = '0;
      end else if (r_row_cnt == ROW_LAST) begin
        w_row_nxt    = '0;
        w_stripe_nxt = (r_stripe == STRIPE_LAST) ? r_stripe : r_stripe + 1'b1;
      end else begin
        w_row_nxt = r_row_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_cnt <= '0;
      r_stripe  <= '0;
    end else begin
      r_row_cnt <= w_row_nxt;
      r_stripe  <= w_stripe_nxt;
    end
  end

  // Frame/phase counters; phase only advances while a moving mode is active
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
      r_phase     <= '0;
      r_mode_q    <= MODE_STATIC;
    end else if (w_frame_edge) begin
      r_mode_q    <= mode_e'(i_mode);
      r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + 1'b1;
      if (!w_phase_run)
        r_phase <= '0;
      else if (w_frame_wrap)
        r_phase <= (r_phase == STRIPE_LAST) ? '0 : r_phase + 1'b1;
    end
  end

  // Palette index: scroll rotates by phase modulo the stripe count
  assign w_sum = {1'b0, w_stripe_nxt} + {1'b0, r_phase};

  always_comb begin
    w_pal_idx = w_stripe_nxt;
    if (r_mode_q == MODE_SCROLL)
      w_pal_idx = (w_sum >= STRIPE_NUM) ? SW'(w_sum - STRIPE_NUM) : w_sum[SW-1:0];
  end

  always_comb begin
    w_pal_rgb = PALETTE[RGB_W-1:0];
    for (int i = 0; i < NUM_STRIPES; i++) begin
      if (w_pal_idx == SW'(i))
        w_pal_rgb = PALETTE[i*RGB_W +: RGB_W];
    end
  end

  assign w_stripe_rgb = ((r_mode_q == MODE_BREATHE) && r_phase[0]) ?
                        dim_rgb(w_pal_rgb) : w_pal_rgb;

`ifdef FLAG_EMBLEM_EN
  logic w_emb_hit;

  flag_emblem u_emblem (
    .i_pix_x (i_pix_x),
    .i_pix_y (i_pix_y),
    .o_hit   (w_emb_hit)
  );
`endif

  always_comb begin
    w_color_nxt = '0;
    if (w_visible) begin
      w_color_nxt = w_stripe_rgb;
`ifdef FLAG_EMBLEM_EN
      if (w_emb_hit)
        w_color_nxt = EMB_COLOR;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_color <= '0;
    else
      r_color <= w_color_nxt;
  end

  assign o_color = r_color;

endmodule

// File: tb/tb_flag_stripes_anim.sv
module tb_flag_stripes_anim;

  localparam int N   = 3;
  localparam int VA  = 480;
  localparam int SH  = VA / N;
  localparam int SPD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_active;
  logic [1:0] mode;
  logic [5:0] color;

  always #5 clk = ~clk;

  flag_stripes_anim #(.SPEED(SPD)) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pix_x        (pix_x),
    .i_pix_y        (pix_y),
    .i_video_active (video_active),
    .i_mode         (mode),
    .o_color        (color)
  );

  int n_chk = 0;
  int n_err = 0;

  // Stripe colours top to bottom: blue, red, black
  logic [5:0] pal [N] = '{6'b000011, 6'b110000, 6'b000000};

  // Reference state: latched mode, animation phase, frames seen, alignment
  int m_mq;
  int m_ph;
  int m_frames;
  bit m_aligned;

  task automatic chk_eq(input string tag, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

`ifdef FLAG_EMBLEM_EN
  function automatic bit emb_hit(input int x, input int y);
    bit bar;
    bit leg;
    bar = (x >= 250 && x < 390) && (y >= 190 && y < 210);
    leg = (y >= 210 && y < 300) &&
          ((x >= 280 && x < 300) || (x >= 340 && x < 360));
    return bar || leg;
  endfunction
`endif

  function automatic logic [5:0] model_rgb(input int x, input int y, input bit v);
    int s;
    int idx;
    int r;
    logic [5:0] c;
    if (!v) return 6'b000000;
`ifdef FLAG_EMBLEM_EN
    if (emb_hit(x, y)) return 6'b111100;
`endif
    s = y / SH;
    if (s > N - 1) s = N - 1;
    idx = (m_mq == 1) ? (s + m_ph) % N : s;
    c = pal[idx];
    if (m_mq == 2 && (m_ph % 2) == 1) begin
      r = 0;
      for (int k = 0; k < 3; k++)
        r += ((int'(c) >> (2 * k)) % 4 / 2) << (2 * k);
      c = 6'(r);
    end
    return c;
  endfunction

  task automatic px(input int x, input int y, input bit v);
    logic [5:0] e;
    bit ok;
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_active = v;
    if (x == 0 && y == 0) m_aligned = 1;
    e = model_rgb(x, y, v);
    ok = m_aligned;
    if (x == 0 && y == VA) begin
      // frame boundary: phase rule uses the mode of the frame just ending
      if (m_mq == 1 || m_mq == 2) begin
        if (m_frames % SPD == SPD - 1) m_ph = (m_ph + 1) % N;
      end else begin
        m_ph = 0;
      end
      m_frames++;
      m_mq = int'(mode);
    end
    @(posedge clk);
    #1;
    if (ok) chk_eq($sformatf("px(%0d,%0d)", x, y), color, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_async", color, 6'b000000);
    @(posedge clk);
    #1;
    chk_eq("rst_hold", color, 6'b000000);
    m_mq = 0;
    m_ph = 0;
    m_frames = 0;
    m_aligned = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input logic [1:0] m0, input int chg, input logic [1:0] m1,
                           input int rst_line, input bit directed);
    for (int y = 0; y <= VA; y++) begin
      mode = (y >= chg) ? m1 : m0;
      px(0, y, y < VA);
      if (y < VA) begin
        if (y == 0 || y == 200) px(10, y, 1'b1);
        if (directed) begin
          if (y == 0)   begin px(10, 0, 1'b1);   chk_eq("tp_y0",   color, 6'b000011); end
          if (y == 159) begin px(10, 159, 1'b1); chk_eq("tp_y159", color, 6'b000011); end
          if (y == 160) begin
            px(10, 160, 1'b1); chk_eq("tp_y160", color, 6'b110000);
            px(10, 160, 1'b0); chk_eq("tp_blank", color, 6'b000000);
          end
          if (y == 320) begin px(10, 320, 1'b1); chk_eq("tp_y320", color, 6'b000000); end
`ifdef FLAG_EMBLEM_EN
          if (y == 195) begin px(300, 195, 1'b1); chk_eq("emb_bar",  color, 6'b111100); end
          if (y == 250) begin
            px(285, 250, 1'b1); chk_eq("emb_leg", color, 6'b111100);
            px(320, 250, 1'b1); chk_eq("emb_gap", color, 6'b110000);
          end
`else
          if (y == 195) begin px(300, 195, 1'b1); chk_eq("no_emb", color, 6'b110000); end
`endif
        end
        repeat (2) px(int'($urandom_range(1, 639)), y, $urandom_range(0, 7) != 0);
      end
      if (y == rst_line) do_reset();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pix_x = '0;
    pix_y = '0;
    video_active = 1'b0;
    mode = 2'd0;
    m_mq = 0;
    m_ph = 0;
    m_frames = 0;
    m_aligned = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_color", color, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    // static frame with test-plan points, scroll latched at its end
    run_frame(2'd1, 1 << 20, 2'd1, -1, 1'b1);
    repeat (6) run_frame(2'd1, 1 << 20, 2'd1, -1, 1'b0);
    // 1 -> 0 mid-frame: this frame keeps scrolling, next one is static
    run_frame(2'd1, 100, 2'd0, -1, 1'b0);
    run_frame(2'd2, 1 << 20, 2'd2, -1, 1'b0);
    repeat (4) run_frame(2'd2, 1 << 20, 2'd2, -1, 1'b0);
    // reset pulse mid-frame, then realignment at the next y==0
    run_frame(2'd1, 1 << 20, 2'd1, 250, 1'b0);
    run_frame(2'd1, 1 << 20, 2'd1, -1, 1'b0);
    repeat (3) run_frame(2'($urandom_range(0, 3)), int'($urandom_range(0, VA)),
                         2'($urandom_range(0, 3)), -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
